// File: rtl/tagged_reorder_queue.sv
// tagged_reorder_queue: hands out tags, buffers tagged writes in any order, and releases the data in tag-allocation order.
// Ports: clk, rst (async, active-high); alloc_req/alloc_gnt/alloc_tag/full (tag allocation);
// wr_en/d (tagged write, tag in d[TAG_LSB+ADDR_W:TAG_LSB]); q/valid/ready (in-order output);
// count (tags allocated and not yet moved to q); err (sticky bad write); init_done (occupancy sweep finished).
module tagged_reorder_queue #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 32,
  parameter int TAG_LSB = 0,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [ADDR_W:0]   alloc_tag,
  output logic              full,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic              valid,
  input  logic              ready,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] sweep;
  logic [ADDR_W:0] beg_ptr, end_ptr, wtag;
  logic [DEPTH-1:0] occ;
  logic [WIDTH-1:0] ram [DEPTH];
  logic wr_ok, retire;
  assign init_done = state == RUN;
  assign full      = count == (ADDR_W+1)'(DEPTH);
  assign alloc_gnt = alloc_req && !full && init_done;
  assign alloc_tag = end_ptr;
  assign wtag      = d[TAG_LSB+ADDR_W:TAG_LSB];
  // Modular distance from the head keeps the window check correct across phase-bit wraps.
  assign wr_ok     = wr_en && init_done && (wtag - beg_ptr) < count && !occ[wtag[ADDR_W-1:0]];
  assign retire    = init_done && occ[beg_ptr[ADDR_W-1:0]] && (!valid || ready);
  always_comb state_nx = (state == INIT && sweep == ADDR_W'(DEPTH-1)) ? RUN : state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      sweep   <= '0;
      beg_ptr <= '0;
      end_ptr <= '0;
      count   <= '0;
      valid   <= 1'b0;
      q       <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (!init_done) sweep <= sweep + ADDR_W'(1);
      if (alloc_gnt) end_ptr <= end_ptr + (ADDR_W+1)'(1);
      if (retire) beg_ptr <= beg_ptr + (ADDR_W+1)'(1);
      count <= count + (ADDR_W+1)'(alloc_gnt) - (ADDR_W+1)'(retire);
      valid <= retire || (valid && !ready);
      if (retire) q <= ram[beg_ptr[ADDR_W-1:0]];
      if (wr_en && !wr_ok) err <= 1'b1;
    end
  end
  // Occupancy and data are not reset; the INIT sweep clears occupancy and nothing reads it before RUN.
  always_ff @(posedge clk) begin
    if (!init_done) occ[sweep] <= 1'b0;
    if (retire) occ[beg_ptr[ADDR_W-1:0]] <= 1'b0;
    if (wr_ok) begin
      occ[wtag[ADDR_W-1:0]] <= 1'b1;
      ram[wtag[ADDR_W-1:0]] <= d;
    end
  end
endmodule
